// File: rtl/exu_redirect_if.sv
`default_nettype none
// ============================================================================
// Module      : exu_redirect_if
// Description : Redirect handshake bundle between the EXU redirect sequencer
//               and the IFU PC mux (valid/ready with target and source tag).
// Revision    : 1.0 - initial release
// ============================================================================
interface exu_redirect_if #(
  parameter int ADDR_W = 32
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        src;

  // Redirect producer (EXU side)
  modport master (
    output valid,
    output addr,
    output src,
    input  ready
  );

  // Redirect consumer (IFU side)
  modport slave (
    input  valid,
    input  addr,
    input  src,
    output ready
  );
endinterface
`default_nettype wire

// File: rtl/exu_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : exu_redirect_ctrl
// Description : Arbitrates BRU / FENCE / interrupt redirects, holds the winning
//               target until the IFU accepts it, pulses a pipeline flush and
//               keeps a kill window open so wrong-path results are squashed.
// Revision    : 1.0 - initial release
// ============================================================================
module exu_redirect_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 3
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              bru_jump_flag_i,
  input  wire logic [ADDR_W-1:0] bru_jump_addr_i,
  input  wire logic              fence_req_i,
  input  wire logic [ADDR_W-1:0] fence_addr_i,
  input  wire logic              int_assert_i,
  input  wire logic [ADDR_W-1:0] int_addr_i,
  exu_redirect_if.master         redir,
  output logic                   flush_o,
  output logic                   kill_o,
  output logic                   busy_o,
  output logic                   int_ack_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REDIR = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  localparam logic [1:0] c_src_none  = 2'd0;
  localparam logic [1:0] c_src_bru   = 2'd1;
  localparam logic [1:0] c_src_fence = 2'd2;
  localparam logic [1:0] c_src_int   = 2'd3;

  // Instruction targets are at least halfword aligned; bit 0 is always cleared.
  localparam logic [ADDR_W-1:0] c_addr_mask = {{(ADDR_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0]  c_cnt_init  =
      CNT_W'((FLUSH_CYCLES > 0) ? (FLUSH_CYCLES - 1) : 0);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        src_q, src_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              flush_q, flush_d;
  logic              kill_q, kill_d;
  logic              busy_q, busy_d;
  logic              int_ack_q, int_ack_d;

  logic w_int_req;
  logic w_hs;

  // The interrupt source still holds its level during the ack cycle, so mask
  // it there to avoid taking the same interrupt twice.
  assign w_int_req = int_assert_i & ~int_ack_q;
  assign w_hs      = valid_q & redir.ready;

  // Next-state and registered-output computation
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    src_d     = src_q;
    cnt_d     = cnt_q;
    flush_d   = 1'b0;
    int_ack_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_int_req) begin
          state_d = S_REDIR;
          addr_d  = int_addr_i & c_addr_mask;
          src_d   = c_src_int;
          flush_d = 1'b1;
        end else if (bru_jump_flag_i) begin
          state_d = S_REDIR;
          addr_d  = bru_jump_addr_i & c_addr_mask;
          src_d   = c_src_bru;
          flush_d = 1'b1;
        end else if (fence_req_i) begin
          state_d = S_REDIR;
          addr_d  = fence_addr_i & c_addr_mask;
          src_d   = c_src_fence;
          flush_d = 1'b1;
        end
      end

      S_REDIR: begin
        if (w_hs) begin
          if (src_q == c_src_int) begin
            int_ack_d = 1'b1;
          end
          if (w_int_req && (src_q != c_src_int)) begin
            // Interrupt collided with a non-INT acceptance: redirect again.
            addr_d  = int_addr_i & c_addr_mask;
            src_d   = c_src_int;
            flush_d = 1'b1;
          end else if (FLUSH_CYCLES == 0) begin
            state_d = S_IDLE;
            src_d   = c_src_none;
          end else begin
            state_d = S_FLUSH;
            src_d   = c_src_none;
            cnt_d   = c_cnt_init;
          end
        end else if (w_int_req && (src_q != c_src_int)) begin
          // Interrupt preempts a not-yet-accepted BRU/FENCE redirect.
          addr_d  = int_addr_i & c_addr_mask;
          src_d   = c_src_int;
          flush_d = 1'b1;
        end
      end

      S_FLUSH: begin
        if (w_int_req) begin
          state_d = S_REDIR;
          addr_d  = int_addr_i & c_addr_mask;
          src_d   = c_src_int;
          flush_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        src_d   = c_src_none;
      end
    endcase

    valid_d = (state_d == S_REDIR);
    kill_d  = (state_d != S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  // State and output registers; reset drops any pending redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      src_q     <= c_src_none;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      flush_q   <= 1'b0;
      kill_q    <= 1'b0;
      busy_q    <= 1'b0;
      int_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      src_q     <= src_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      flush_q   <= flush_d;
      kill_q    <= kill_d;
      busy_q    <= busy_d;
      int_ack_q <= int_ack_d;
    end
  end

  assign redir.valid = valid_q;
  assign redir.addr  = addr_q;
  assign redir.src   = src_q;
  assign flush_o     = flush_q;
  assign kill_o      = kill_q;
  assign busy_o      = busy_q;
  assign int_ack_o   = int_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_exu_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_exu_redirect_ctrl
// Description : Directed bench for exu_redirect_ctrl; accepted redirects are
//               matched against a queue of expected (addr, src) pairs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exu_redirect_ctrl;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT A: default kill window
  logic              bru_a, fence_a, int_a;
  logic [ADDR_W-1:0] bru_addr_a, fence_addr_a, int_addr_a;
  logic              flush_a, kill_a, busy_a, ack_a;
  exu_redirect_if #(.ADDR_W(ADDR_W)) rif_a ();

  // DUT B: kill window disabled
  logic              bru_b, fence_b, int_b;
  logic [ADDR_W-1:0] bru_addr_b, fence_addr_b, int_addr_b;
  logic              flush_b, kill_b, busy_b, ack_b;
  exu_redirect_if #(.ADDR_W(ADDR_W)) rif_b ();

  exu_redirect_ctrl #(.ADDR_W(ADDR_W), .FLUSH_CYCLES(2), .CNT_W(3)) u_dut_a (
    .clk             (clk),
    .rst_n           (rst_n),
    .bru_jump_flag_i (bru_a),
    .bru_jump_addr_i (bru_addr_a),
    .fence_req_i     (fence_a),
    .fence_addr_i    (fence_addr_a),
    .int_assert_i    (int_a),
    .int_addr_i      (int_addr_a),
    .redir           (rif_a),
    .flush_o         (flush_a),
    .kill_o          (kill_a),
    .busy_o          (busy_a),
    .int_ack_o       (ack_a)
  );

  exu_redirect_ctrl #(.ADDR_W(ADDR_W), .FLUSH_CYCLES(0), .CNT_W(3)) u_dut_b (
    .clk             (clk),
    .rst_n           (rst_n),
    .bru_jump_flag_i (bru_b),
    .bru_jump_addr_i (bru_addr_b),
    .fence_req_i     (fence_b),
    .fence_addr_i    (fence_addr_b),
    .int_assert_i    (int_b),
    .int_addr_i      (int_addr_b),
    .redir           (rif_b),
    .flush_o         (flush_b),
    .kill_o          (kill_b),
    .busy_o          (busy_b),
    .int_ack_o       (ack_b)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        src;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Packed status {valid, src[1:0], flush, kill, busy, int_ack}
  task automatic st_a(input string tag, input logic v, input logic [1:0] s,
                      input logic f, input logic k, input logic b, input logic ack);
    chk(tag, 32'({rif_a.valid, rif_a.src, flush_a, kill_a, busy_a, ack_a}),
        32'({v, s, f, k, b, ack}));
  endtask

  task automatic st_b(input string tag, input logic v, input logic [1:0] s,
                      input logic f, input logic k, input logic b, input logic ack);
    chk(tag, 32'({rif_b.valid, rif_b.src, flush_b, kill_b, busy_b, ack_b}),
        32'({v, s, f, k, b, ack}));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [ADDR_W-1:0] a, input logic [1:0] s);
    exp_t e;
    e.addr = a;
    e.src  = s;
    sb_q.push_back(e);
  endtask

  // Handshake monitor: every accepted redirect on A must match the queue head
  always @(negedge clk) begin
    if (rst_n && rif_a.valid && rif_a.ready) begin
      if (sb_q.size() == 0) begin
        chk("sb.pending", 32'(sb_q.size()), 32'd1);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb.addr", rif_a.addr, mon_e.addr);
        chk("sb.src", 32'(rif_a.src), 32'(mon_e.src));
      end
    end
  end

  initial begin
    bru_a = 0; fence_a = 0; int_a = 0;
    bru_addr_a = '0; fence_addr_a = '0; int_addr_a = '0;
    bru_b = 0; fence_b = 0; int_b = 0;
    bru_addr_b = '0; fence_addr_b = '0; int_addr_b = '0;
    rif_a.ready = 0;
    rif_b.ready = 0;
    rst_n = 1;
    #2 rst_n = 0;
    #1;
    st_a("reset.a", 0, 0, 0, 0, 0, 0);
    chk("reset.addr", rif_a.addr, 32'h0);
    st_b("reset.b", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1;
    tick();
    st_a("idle.a", 0, 0, 0, 0, 0, 0);

    // BRU jump, IFU ready immediately
    push(32'h0000_1002, 2'd1);
    bru_a = 1; bru_addr_a = 32'h0000_1003; rif_a.ready = 1;
    tick();
    st_a("bru.redir", 1, 1, 1, 1, 1, 0);
    chk("bru.addr", rif_a.addr, 32'h0000_1002);
    bru_a = 0;
    tick();
    st_a("bru.flush1", 0, 0, 0, 1, 1, 0);
    tick();
    st_a("bru.flush2", 0, 0, 0, 1, 1, 0);
    tick();
    st_a("bru.idle", 0, 0, 0, 0, 0, 0);

    // INT, BRU and FENCE together: INT wins
    push(32'h8000_0000, 2'd3);
    int_a = 1; int_addr_a = 32'h8000_0000;
    bru_a = 1; bru_addr_a = 32'h0000_0100;
    fence_a = 1; fence_addr_a = 32'h0000_0044;
    rif_a.ready = 0;
    tick();
    st_a("prio.redir", 1, 3, 1, 1, 1, 0);
    chk("prio.addr", rif_a.addr, 32'h8000_0000);
    bru_a = 0; fence_a = 0; rif_a.ready = 1;
    tick();
    st_a("prio.ack", 0, 0, 0, 1, 1, 1);
    rif_a.ready = 0;
    tick();
    st_a("prio.norecap", 0, 0, 0, 1, 1, 0);
    int_a = 0;
    tick();
    st_a("prio.idle", 0, 0, 0, 0, 0, 0);

    // BRU stalled by IFU, INT preempts on the second stalled cycle
    push(32'h0000_0AB0, 2'd3);
    bru_a = 1; bru_addr_a = 32'h0000_0200;
    tick();
    st_a("pre.redir", 1, 1, 1, 1, 1, 0);
    chk("pre.addr0", rif_a.addr, 32'h0000_0200);
    bru_a = 0;
    tick();
    st_a("pre.hold", 1, 1, 0, 1, 1, 0);
    chk("pre.addr1", rif_a.addr, 32'h0000_0200);
    int_a = 1; int_addr_a = 32'h0000_0AB1;
    tick();
    st_a("pre.swap", 1, 3, 1, 1, 1, 0);
    chk("pre.addr2", rif_a.addr, 32'h0000_0AB0);
    tick();
    st_a("pre.hold2", 1, 3, 0, 1, 1, 0);
    rif_a.ready = 1;
    tick();
    st_a("pre.ack", 0, 0, 0, 1, 1, 1);
    int_a = 0; rif_a.ready = 0;
    tick();
    st_a("pre.flush", 0, 0, 0, 1, 1, 0);
    tick();
    st_a("pre.idle", 0, 0, 0, 0, 0, 0);

    // BRU during the kill window is ignored
    push(32'h0000_0300, 2'd1);
    bru_a = 1; bru_addr_a = 32'h0000_0300; rif_a.ready = 1;
    tick();
    st_a("win.redir", 1, 1, 1, 1, 1, 0);
    bru_a = 0;
    tick();
    st_a("win.flush1", 0, 0, 0, 1, 1, 0);
    bru_a = 1; bru_addr_a = 32'h0000_0400;
    tick();
    st_a("win.ignored", 0, 0, 0, 1, 1, 0);
    bru_a = 0; rif_a.ready = 0;
    tick();
    st_a("win.idle", 0, 0, 0, 0, 0, 0);

    // INT on the last kill-window cycle
    push(32'h0000_0500, 2'd1);
    push(32'h0000_0900, 2'd3);
    bru_a = 1; bru_addr_a = 32'h0000_0500; rif_a.ready = 1;
    tick();
    st_a("last.redir", 1, 1, 1, 1, 1, 0);
    bru_a = 0;
    tick();
    st_a("last.flush1", 0, 0, 0, 1, 1, 0);
    rif_a.ready = 0;
    tick();
    st_a("last.flush2", 0, 0, 0, 1, 1, 0);
    int_a = 1; int_addr_a = 32'h0000_0900;
    tick();
    st_a("last.int", 1, 3, 1, 1, 1, 0);
    chk("last.addr", rif_a.addr, 32'h0000_0900);
    rif_a.ready = 1;
    tick();
    st_a("last.ack", 0, 0, 0, 1, 1, 1);
    int_a = 0; rif_a.ready = 0;
    tick();
    st_a("last.flush", 0, 0, 0, 1, 1, 0);
    tick();
    st_a("last.idle", 0, 0, 0, 0, 0, 0);

    // No kill window: INT handshake returns straight to IDLE
    int_b = 1; int_addr_b = 32'h0000_0C01; rif_b.ready = 1;
    tick();
    st_b("nowin.redir", 1, 3, 1, 1, 1, 0);
    chk("nowin.addr", rif_b.addr, 32'h0000_0C00);
    tick();
    st_b("nowin.ack", 0, 0, 0, 0, 0, 1);
    tick();
    st_b("nowin.norecap", 0, 0, 0, 0, 0, 0);
    int_b = 0; rif_b.ready = 0;
    tick();
    st_b("nowin.idle", 0, 0, 0, 0, 0, 0);

    // Asynchronous reset while a redirect is pending
    bru_a = 1; bru_addr_a = 32'h0000_0600;
    tick();
    st_a("rst.redir", 1, 1, 1, 1, 1, 0);
    bru_a = 0;
    #2 rst_n = 0;
    #1;
    st_a("rst.async", 0, 0, 0, 0, 0, 0);
    chk("rst.addr", rif_a.addr, 32'h0);
    tick();
    st_a("rst.held", 0, 0, 0, 0, 0, 0);
    rst_n = 1;
    tick();
    st_a("rst.idle", 0, 0, 0, 0, 0, 0);

    push(32'h0000_1002, 2'd1);
    bru_a = 1; bru_addr_a = 32'h0000_1003; rif_a.ready = 1;
    tick();
    st_a("again.redir", 1, 1, 1, 1, 1, 0);
    chk("again.addr", rif_a.addr, 32'h0000_1002);
    bru_a = 0;
    tick();
    st_a("again.flush1", 0, 0, 0, 1, 1, 0);
    rif_a.ready = 0;
    tick();
    st_a("again.flush2", 0, 0, 0, 1, 1, 0);
    tick();
    st_a("again.idle", 0, 0, 0, 0, 0, 0);

    chk("sb.drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
